presubaddor_stream_adapter: RTL



---
 rtl/presubaddor_stream_adapter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/presubaddor_stream_adapter.sv
// presubaddor_stream_adapter
// Valid/ready front-end for a fixed-latency pre-subtract/multiply/add
// datapath: out = ((d - a) * b) + c, modulo 2^WIDTH.
//
// Accepted beats go through a 2-stage pipeline that never stalls. Results
// land in a small FIFO. in_ready is granted only while the FIFO entries plus
// the in-flight beats total less than FIFO_DEPTH. This guarantees that every
// pipeline write finds a free FIFO slot.
//
// Optional feature macro: PRESUBADDOR_OVF_FLAG_EN
//   Adds out_ovf. It is set when the full-precision signed result is
//   negative or does not fit in WIDTH bits. The flag travels with its result.

// Overflow checker: a pipeline write must never find the FIFO full.
module presubaddor_stream_adapter_chk #(
    parameter int CW         = 3,
    parameter int FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push_i,
    input logic [CW-1:0] count_i
);

    // A push is only legal while the FIFO still has a free entry
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push_i |-> (count_i < CW'(FIFO_DEPTH)));

endmodule

module presubaddor_stream_adapter #(
    parameter int WIDTH      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
`ifdef PRESUBADDOR_OVF_FLAG_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = PW + 2;
`ifdef PRESUBADDOR_OVF_FLAG_EN
    localparam int EW = WIDTH + 1;
    localparam int FW = 2 * WIDTH + 3;
`else
    localparam int EW = WIDTH;
`endif

    logic          en_q;
    logic          v0_q;
    logic          v1_q;
    logic [EW-1:0] s0_q;
    logic [EW-1:0] s1_q;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [EW-1:0] entry_s;
    logic [EW-1:0] head_s;
    logic [OW-1:0] occ_s;
    logic          in_ready_s;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic          nonempty_s;

`ifdef PRESUBADDOR_OVF_FLAG_EN
    logic signed [FW-1:0] d_x, a_x, b_x, c_x, full_s;

    // Full-precision signed datapath; the low WIDTH bits equal the modulo result
    always_comb begin
        d_x     = $signed({{(FW-WIDTH){1'b0}}, d});
        a_x     = $signed({{(FW-WIDTH){1'b0}}, a});
        b_x     = $signed({{(FW-WIDTH){1'b0}}, b});
        c_x     = $signed({{(FW-WIDTH){1'b0}}, c});
        full_s  = ((d_x - a_x) * b_x) + c_x;
        entry_s = {(full_s[FW-1] | (|full_s[FW-2:WIDTH])), full_s[WIDTH-1:0]};
    end
`else
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] mul_s;

    // Modulo 2^WIDTH datapath: wrap the subtraction, truncate the product, wrap the add
    always_comb begin
        diff_s  = d - a;
        mul_s   = diff_s * b;
        entry_s = mul_s + c;
    end
`endif

    // Credit accounting: in-flight beats already own a FIFO slot
    always_comb begin
        occ_s      = OW'(count_q) + OW'(v0_q) + OW'(v1_q);
        in_ready_s = en_q && (occ_s < OW'(FIFO_DEPTH));
        accept_s   = in_valid && in_ready_s;
        push_s     = v1_q;
        nonempty_s = (count_q != '0);
        pop_s      = nonempty_s && out_ready;
    end

    // FIFO pointer and occupancy next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Ready enable: hold off acceptance until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= 1'b1;
        end
    end

    // Two-stage compute pipeline; valid bits advance every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            s0_q <= '0;
            s1_q <= '0;
        end else begin
            v0_q <= accept_s;
            v1_q <= v0_q;
            s0_q <= entry_s;
            s1_q <= s0_q;
        end
    end

    // Result FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= s1_q;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head presentation: outputs read zero whenever the FIFO is empty
    always_comb begin
        head_s = mem_q[rd_ptr_q];
        if (nonempty_s) begin
            out = head_s[WIDTH-1:0];
        end else begin
            out = '0;
        end
`ifdef PRESUBADDOR_OVF_FLAG_EN
        if (nonempty_s) begin
            out_ovf = head_s[EW-1];
        end else begin
            out_ovf = 1'b0;
        end
`endif
    end

    assign in_ready  = in_ready_s;
    assign out_valid = nonempty_s;

    presubaddor_stream_adapter_chk #(
        .CW         (CW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .count_i (count_q)
    );

endmodule
